// File: rtl/axi_lite_initiator.sv
// Single-outstanding AXI4-Lite master: local cmd/rsp requests in, AXI4-Lite
// read/write transactions out, plus a sticky watchdog for stuck transactions.
module axi_lite_initiator #(
  parameter int unsigned AXI_ADDR_BW_p = 12,
  parameter int unsigned TIMEOUT_p     = 256
) (
  input  logic                     clk,
  input  logic                     rst,
  // command request
  input  logic                     i_cmd_valid,
  output logic                     o_cmd_ready,
  input  logic                     i_cmd_we,
  input  logic [AXI_ADDR_BW_p-1:0] i_cmd_addr,
  input  logic [31:0]              i_cmd_wdata,
  // response
  output logic                     o_rsp_valid,
  input  logic                     i_rsp_ready,
  output logic [31:0]              o_rsp_rdata,
  output logic [1:0]               o_rsp_resp,
  output logic                     o_rsp_we,
  output logic                     o_timeout,
  // AXI write address / data / response
  output logic [AXI_ADDR_BW_p-1:0] o_axi_awaddr,
  output logic                     o_axi_awvalid,
  input  logic                     i_axi_awready,
  output logic [31:0]              o_axi_wdata,
  output logic                     o_axi_wvalid,
  input  logic                     i_axi_wready,
  input  logic [1:0]               i_axi_bresp,
  input  logic                     i_axi_bvalid,
  output logic                     o_axi_bready,
  // AXI read address / data
  output logic [AXI_ADDR_BW_p-1:0] o_axi_araddr,
  output logic                     o_axi_arvalid,
  input  logic                     i_axi_arready,
  input  logic [31:0]              i_axi_rdata,
  input  logic [1:0]               i_axi_rresp,
  input  logic                     i_axi_rvalid,
  output logic                     o_axi_rready
);

  localparam int unsigned CNT_W = (TIMEOUT_p > 0) ? $clog2(TIMEOUT_p + 1) : 1;
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT_p);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_READ  = 2'd2,
    S_RSP   = 2'd3
  } state_t;

  state_t           state;
  logic             aw_done;
  logic             w_done;
  logic [CNT_W-1:0] wd_cnt;
  logic             busy;

  // Ready/bready decode straight from state and the per-channel done flags
  assign o_cmd_ready  = (state == S_IDLE) && !rst;
  assign o_axi_bready = (state == S_WRITE) && aw_done && w_done && !rst;
  assign busy         = (state == S_WRITE) || (state == S_READ);

  // Transaction FSM, registered AXI/response outputs and watchdog
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      aw_done       <= 1'b0;
      w_done        <= 1'b0;
      wd_cnt        <= '0;
      o_timeout     <= 1'b0;
      o_rsp_valid   <= 1'b0;
      o_rsp_rdata   <= '0;
      o_rsp_resp    <= '0;
      o_rsp_we      <= 1'b0;
      o_axi_awaddr  <= '0;
      o_axi_awvalid <= 1'b0;
      o_axi_wdata   <= '0;
      o_axi_wvalid  <= 1'b0;
      o_axi_araddr  <= '0;
      o_axi_arvalid <= 1'b0;
      o_axi_rready  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_cmd_valid) begin
            o_rsp_rdata <= '0;
            o_rsp_resp  <= '0;
            o_rsp_we    <= i_cmd_we;
            wd_cnt      <= '0;
            o_timeout   <= 1'b0;
            if (i_cmd_we) begin
              state         <= S_WRITE;
              o_axi_awaddr  <= i_cmd_addr;
              o_axi_wdata   <= i_cmd_wdata;
              o_axi_awvalid <= 1'b1;
              o_axi_wvalid  <= 1'b1;
              aw_done       <= 1'b0;
              w_done        <= 1'b0;
            end else begin
              state         <= S_READ;
              o_axi_araddr  <= i_cmd_addr;
              o_axi_arvalid <= 1'b1;
              o_axi_rready  <= 1'b1;
            end
          end
        end
        S_WRITE: begin
          // AW and W retire independently, in either order
          if (o_axi_awvalid && i_axi_awready) begin
            o_axi_awvalid <= 1'b0;
            aw_done       <= 1'b1;
          end
          if (o_axi_wvalid && i_axi_wready) begin
            o_axi_wvalid <= 1'b0;
            w_done       <= 1'b1;
          end
          if (o_axi_bready && i_axi_bvalid) begin
            o_rsp_resp  <= i_axi_bresp;
            o_rsp_valid <= 1'b1;
            aw_done     <= 1'b0;
            w_done      <= 1'b0;
            state       <= S_RSP;
          end
        end
        S_READ: begin
          if (o_axi_arvalid && i_axi_arready) begin
            o_axi_arvalid <= 1'b0;
          end
          if (o_axi_rready && i_axi_rvalid) begin
            o_rsp_rdata  <= i_axi_rdata;
            o_rsp_resp   <= i_axi_rresp;
            o_rsp_valid  <= 1'b1;
            o_axi_rready <= 1'b0;
            state        <= S_RSP;
          end
        end
        S_RSP: begin
          if (i_rsp_ready) begin
            o_rsp_valid <= 1'b0;
            state       <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase

      // Watchdog counts busy cycles and saturates at the limit; it never aborts
      if ((TIMEOUT_p != 0) && busy && (wd_cnt != TIMEOUT_C)) begin
        wd_cnt <= wd_cnt + CNT_W'(1);
        if ((wd_cnt + CNT_W'(1)) == TIMEOUT_C) begin
          o_timeout <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_axi_lite_initiator.sv
// Self-checking bench: behavioural AXI-Lite slave with configurable latencies,
// a word-memory reference model, directed timing cases and randomized traffic.
module tb_axi_lite_initiator;

  localparam int unsigned AW = 12;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_cmd_valid, o_cmd_ready, i_cmd_we;
  logic [AW-1:0] i_cmd_addr;
  logic [31:0]   i_cmd_wdata;
  logic          o_rsp_valid, i_rsp_ready, o_rsp_we, o_timeout;
  logic [31:0]   o_rsp_rdata;
  logic [1:0]    o_rsp_resp;
  logic [AW-1:0] o_axi_awaddr, o_axi_araddr;
  logic          o_axi_awvalid, i_axi_awready, o_axi_wvalid, i_axi_wready;
  logic [31:0]   o_axi_wdata, i_axi_rdata;
  logic [1:0]    i_axi_bresp, i_axi_rresp;
  logic          i_axi_bvalid, o_axi_bready;
  logic          o_axi_arvalid, i_axi_arready, i_axi_rvalid, o_axi_rready;

  axi_lite_initiator #(.AXI_ADDR_BW_p(AW), .TIMEOUT_p(TO)) dut (
    .clk(clk), .rst(rst),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready), .i_cmd_we(i_cmd_we),
    .i_cmd_addr(i_cmd_addr), .i_cmd_wdata(i_cmd_wdata),
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready), .o_rsp_rdata(o_rsp_rdata),
    .o_rsp_resp(o_rsp_resp), .o_rsp_we(o_rsp_we), .o_timeout(o_timeout),
    .o_axi_awaddr(o_axi_awaddr), .o_axi_awvalid(o_axi_awvalid), .i_axi_awready(i_axi_awready),
    .o_axi_wdata(o_axi_wdata), .o_axi_wvalid(o_axi_wvalid), .i_axi_wready(i_axi_wready),
    .i_axi_bresp(i_axi_bresp), .i_axi_bvalid(i_axi_bvalid), .o_axi_bready(o_axi_bready),
    .o_axi_araddr(o_axi_araddr), .o_axi_arvalid(o_axi_arvalid), .i_axi_arready(i_axi_arready),
    .i_axi_rdata(i_axi_rdata), .i_axi_rresp(i_axi_rresp), .i_axi_rvalid(i_axi_rvalid),
    .o_axi_rready(o_axi_rready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // ---------------- slave configuration and state ----------------
  int aw_dly, w_dly, b_dly, ar_dly, r_dly;
  bit ovr_en = 1'b0;
  logic [1:0] ovr_resp = 2'b00;
  logic [31:0] slv_mem [0:1023];
  logic [31:0] ref_mem [0:1023];

  bit aw_seen, aw_got, w_seen, w_got, b_pend, ar_seen, ar_got, r_pend;
  int aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
  logic [AW-1:0] aw_a, ar_a;
  logic [31:0] w_d;
  int aw_first, aw_hs, w_first, w_hs, ar_first, ar_hs, bready_first;
  int n_bhs = 0;
  int n_rhs = 0;

  // Address map of the modelled slave: top quarter of the space errors out
  function automatic logic [1:0] addr_resp(input logic [AW-1:0] a);
    if (ovr_en) return ovr_resp;
    if (a[11:10] == 2'b11) return a[9] ? 2'b11 : 2'b10;
    return 2'b00;
  endfunction

  task automatic slave_reset();
    i_axi_awready = 0; i_axi_wready = 0; i_axi_bvalid = 0; i_axi_bresp = 0;
    i_axi_arready = 0; i_axi_rvalid = 0; i_axi_rdata = 0; i_axi_rresp = 0;
    aw_seen = 0; aw_got = 0; w_seen = 0; w_got = 0; b_pend = 0;
    ar_seen = 0; ar_got = 0; r_pend = 0;
    aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
  endtask

  // Slave: decides on the falling edge, so every handshake lands on the next rising edge
  initial begin
    slave_reset();
    forever begin
      @(negedge clk);
      if (rst) begin
        slave_reset();
      end else begin
        // write response
        if (b_pend) begin
          b_pend = 0; i_axi_bvalid = 0; aw_got = 0; w_got = 0;
          aw_seen = 0; w_seen = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
        end
        check("bready", o_axi_bready, aw_got && w_got);
        if (o_axi_bready && bready_first < 0) bready_first = cyc;
        if (aw_got && w_got && !i_axi_bvalid) begin
          if (b_cnt == b_dly) begin
            i_axi_bvalid = 1;
            i_axi_bresp  = addr_resp(aw_a);
            if (i_axi_bresp == 2'b00) slv_mem[aw_a[11:2]] = w_d;
          end else b_cnt++;
        end
        if (i_axi_bvalid && o_axi_bready) begin b_pend = 1; n_bhs++; end
        // write address
        i_axi_awready = 0;
        if (aw_got) check("awvalid_drop", o_axi_awvalid, 0);
        else if (o_axi_awvalid) begin
          if (!aw_seen) begin aw_seen = 1; aw_a = o_axi_awaddr; aw_first = cyc; end
          else check("awaddr_stable", o_axi_awaddr, aw_a);
          if (aw_cnt == aw_dly) begin i_axi_awready = 1; aw_got = 1; aw_hs = cyc; end
          else aw_cnt++;
        end
        // write data
        i_axi_wready = 0;
        if (w_got) check("wvalid_drop", o_axi_wvalid, 0);
        else if (o_axi_wvalid) begin
          if (!w_seen) begin w_seen = 1; w_d = o_axi_wdata; w_first = cyc; end
          else check("wdata_stable", o_axi_wdata, w_d);
          if (w_cnt == w_dly) begin i_axi_wready = 1; w_got = 1; w_hs = cyc; end
          else w_cnt++;
        end
        // read data
        if (r_pend) begin
          r_pend = 0; i_axi_rvalid = 0; ar_got = 0; ar_seen = 0; ar_cnt = 0; r_cnt = 0;
        end
        check("rready", o_axi_rready, o_axi_arvalid || ar_got);
        if (ar_got && !i_axi_rvalid) begin
          if (r_cnt == r_dly) begin
            i_axi_rvalid = 1;
            i_axi_rresp  = addr_resp(ar_a);
            i_axi_rdata  = (i_axi_rresp == 2'b00) ? slv_mem[ar_a[11:2]] : 32'hDEADDEAD;
          end else r_cnt++;
        end
        if (i_axi_rvalid && o_axi_rready) begin r_pend = 1; n_rhs++; end
        // read address
        i_axi_arready = 0;
        if (ar_got) check("arvalid_drop", o_axi_arvalid, 0);
        else if (o_axi_arvalid) begin
          if (!ar_seen) begin ar_seen = 1; ar_a = o_axi_araddr; ar_first = cyc; end
          else check("araddr_stable", o_axi_araddr, ar_a);
          if (ar_cnt == ar_dly) begin i_axi_arready = 1; ar_got = 1; ar_hs = cyc; end
          else ar_cnt++;
        end
      end
    end
  end

  // ---------------- command driver + reference model ----------------
  task automatic run_cmd(input logic we, input logic [AW-1:0] a, input logic [31:0] wd,
                         input int hold, output int t_acc, output int t_rsp, output int t_to);
    int n;
    logic [31:0] exp_rd;
    logic [1:0]  exp_rs;
    logic [34:0] snap;
    t_acc = -1; t_rsp = -1; t_to = -1;
    exp_rs = addr_resp(a);
    if (we) begin
      exp_rd = 32'h0;
      if (exp_rs == 2'b00) ref_mem[a[11:2]] = wd;
    end else begin
      exp_rd = (exp_rs == 2'b00) ? ref_mem[a[11:2]] : 32'hDEADDEAD;
    end
    i_cmd_valid = 1; i_cmd_we = we; i_cmd_addr = a; i_cmd_wdata = wd;
    n = 0;
    while (!o_cmd_ready && n < 50) begin @(negedge clk); n++; end
    check("cmd_ready_wait", o_cmd_ready, 1);
    if (!o_cmd_ready) begin i_cmd_valid = 0; return; end
    t_acc = cyc;
    @(negedge clk);
    i_cmd_valid = 0; i_cmd_we = 1'($urandom); i_cmd_addr = AW'($urandom); i_cmd_wdata = $urandom;
    check("cmd_ready_busy", o_cmd_ready, 0);
    check("timeout_clr", o_timeout, 0);
    n = 0;
    while (!o_rsp_valid && n < 100) begin
      if (o_timeout && t_to < 0) t_to = cyc;
      @(negedge clk); n++;
    end
    check("rsp_valid_wait", o_rsp_valid, 1);
    if (!o_rsp_valid) return;
    t_rsp = cyc;
    if (o_timeout && t_to < 0) t_to = cyc;
    check("rsp_rdata", o_rsp_rdata, exp_rd);
    check("rsp_resp", o_rsp_resp, exp_rs);
    check("rsp_we", o_rsp_we, we);
    check("timeout_at_rsp", o_timeout, (t_rsp - t_acc - 1) >= TO);
    snap = {o_rsp_we, o_rsp_resp, o_rsp_rdata};
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("rsp_hold", {o_rsp_valid, o_rsp_we, o_rsp_resp, o_rsp_rdata}, {1'b1, snap});
      check("cmd_ready_in_rsp", o_cmd_ready, 0);
    end
    i_rsp_ready = 1;
    @(negedge clk);
    i_rsp_ready = 0;
    check("rsp_drop", o_rsp_valid, 0);
    check("cmd_ready_idle", o_cmd_ready, 1);
  endtask

  function automatic logic [127:0] all_outs();
    return 128'({o_cmd_ready, o_rsp_valid, o_rsp_rdata, o_rsp_resp, o_rsp_we, o_timeout,
                 o_axi_awaddr, o_axi_awvalid, o_axi_wdata, o_axi_wvalid, o_axi_bready,
                 o_axi_araddr, o_axi_arvalid, o_axi_rready});
  endfunction

  task automatic set_dly(input int aw, input int w, input int b, input int ar, input int r);
    aw_dly = aw; w_dly = w; b_dly = b; ar_dly = ar; r_dly = r;
  endtask

  initial begin
    #500000;
    $display("FAIL global_time_limit: got expired expected completion");
    $fatal(1, "time limit");
  end

  initial begin
    int ta, tr, tt, nb0;
    logic [AW-1:0] a;
    logic we;
    for (int i = 0; i < 1024; i++) begin slv_mem[i] = 32'h0; ref_mem[i] = 32'h0; end
    rst = 1; i_cmd_valid = 0; i_cmd_we = 0; i_cmd_addr = 0; i_cmd_wdata = 0; i_rsp_ready = 0;
    set_dly(0, 0, 0, 0, 0);
    bready_first = -1;

    // reset state
    repeat (2) @(negedge clk);
    check("reset_outputs", all_outs(), 128'h0);
    rst = 0;
    @(negedge clk);
    check("ready_after_reset", o_cmd_ready, 1);

    // zero-wait write of 0xA5 to 0x000
    run_cmd(1'b1, 12'h000, 32'h000000A5, 0, ta, tr, tt);
    check("wr_aw_first", aw_first, ta + 1);
    check("wr_aw_hs", aw_hs, ta + 1);
    check("wr_w_first", w_first, ta + 1);
    check("wr_w_hs", w_hs, ta + 1);
    check("wr_latency", tr - ta, 3);

    // zero-wait read back
    run_cmd(1'b0, 12'h000, 32'h0, 0, ta, tr, tt);
    check("rd_ar_first", ar_first, ta + 1);
    check("rd_latency", tr - ta, 3);

    // slave errors passed through
    ovr_en = 1; ovr_resp = 2'b10;
    run_cmd(1'b1, 12'h004, 32'h12345678, 0, ta, tr, tt);
    run_cmd(1'b0, 12'h008, 32'h0, 0, ta, tr, tt);
    ovr_en = 0;

    // W accepted immediately, AW accepted three cycles later
    set_dly(3, 0, 0, 0, 0);
    bready_first = -1; nb0 = n_bhs;
    run_cmd(1'b1, 12'h010, 32'hCAFEF00D, 0, ta, tr, tt);
    check("skew_w_hs", w_hs, ta + 1);
    check("skew_aw_hs", aw_hs, ta + 4);
    check("skew_bready_first", bready_first, ta + 5);
    check("skew_one_b", n_bhs - nb0, 1);

    // response held five cycles
    set_dly(0, 0, 0, 0, 0);
    run_cmd(1'b0, 12'h010, 32'h0, 5, ta, tr, tt);

    // watchdog: AR withheld 20 cycles
    set_dly(0, 0, 0, 20, 0);
    run_cmd(1'b0, 12'h000, 32'h0, 0, ta, tr, tt);
    check("timeout_rise", tt, ta + TO + 1);
    check("timeout_sticky", o_timeout, 1);
    set_dly(0, 0, 0, 0, 0);
    run_cmd(1'b1, 12'h020, 32'h0BADBEEF, 0, ta, tr, tt);
    check("timeout_cleared", o_timeout, 0);

    // randomized traffic
    for (int k = 0; k < 150; k++) begin
      a = AW'($urandom);
      if ($urandom_range(0, 3) != 0) a[11:6] = 6'h0;
      we = 1'($urandom);
      set_dly($urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4),
              $urandom_range(0, 4), $urandom_range(0, 4));
      run_cmd(we, a, $urandom, $urandom_range(0, 3), ta, tr, tt);
    end

    // reset in the middle of a stalled write
    set_dly(10, 10, 0, 0, 0);
    i_cmd_valid = 1; i_cmd_we = 1; i_cmd_addr = 12'h030; i_cmd_wdata = 32'h55AA55AA;
    @(negedge clk);
    i_cmd_valid = 0;
    check("midrst_awvalid_before", o_axi_awvalid, 1);
    repeat (2) @(negedge clk);
    rst = 1;
    @(negedge clk);
    check("midrst_outputs", all_outs(), 128'h0);
    rst = 0;
    @(negedge clk);
    check("midrst_ready", o_cmd_ready, 1);
    check("midrst_valids", {o_axi_awvalid, o_axi_wvalid, o_axi_arvalid, o_rsp_valid, o_timeout}, 0);
    set_dly(0, 0, 0, 0, 0);
    run_cmd(1'b0, 12'h030, 32'h0, 0, ta, tr, tt);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_lite_initiator.md
# axi_lite_initiator

Single-outstanding AXI4-Lite master that turns simple command/response requests from local logic (sequencers, test controllers, bring-up FSMs) into AXI4-Lite read and write transactions. Its bus ports mirror the slave peripherals on the same interconnect, such as the LED and GPIO register blocks, so it drops in as the initiating end of that bus. It also provides a sticky watchdog flag for transactions that never complete.

## Interface
- AXI_ADDR_BW_p, 12, AXI address width; matches the slave blocks.
- TIMEOUT_p, 256, watchdog limit in cycles; 0 disables the watchdog.

Ports:
- clk  in  1  clock; one clock domain.
- rst  in  1  reset; synchronous, active-high.
- i_cmd_valid  in  1  command request.
- o_cmd_ready  out  1  command accepted when i_cmd_valid & o_cmd_ready.
- i_cmd_we  in  1  1 = write, 0 = read.
- i_cmd_addr  in  AXI_ADDR_BW_p  byte address.
- i_cmd_wdata  in  32  write data; ignored for reads.
- o_rsp_valid  out  1  response available.
- i_rsp_ready  in  1  response consumed when o_rsp_valid & i_rsp_ready.
- o_rsp_rdata  out  32  read data; 0 for writes.
- o_rsp_resp  out  2  captured BRESP or RRESP.
- o_rsp_we  out  1  echoes i_cmd_we of the completed command.
- o_timeout  out  1  sticky watchdog flag.
- AXI write channels, outputs: o_axi_awaddr[AXI_ADDR_BW_p], o_axi_awvalid, o_axi_wdata[32], o_axi_wvalid, o_axi_bready.
- AXI write channels, inputs: i_axi_awready, i_axi_wready, i_axi_bresp[2], i_axi_bvalid.
- AXI read channels, outputs: o_axi_araddr[AXI_ADDR_BW_p], o_axi_arvalid, o_axi_rready.
- AXI read channels, inputs: i_axi_arready, i_axi_rdata[32], i_axi_rresp[2], i_axi_rvalid.
- The block has no WSTRB or PROT ports; every write is a full 32-bit word.

## Operation
- States:
  - IDLE: o_cmd_ready = 1.
  - WRITE: address/data issued, waiting for B.
  - READ: address issued, waiting for R.
  - RSP: holding the response.
- IDLE → WRITE or READ on command accept. The address and wdata are registered into the AXI output registers; the response registers are cleared.
- WRITE:
  - o_axi_awvalid and o_axi_wvalid assert together.
  - Each channel is tracked by its own done flag (aw_done, w_done).
  - Each valid deasserts in the cycle after its own handshake; the two channels complete independently in either order.
  - o_axi_bready = aw_done & w_done (registered flags).
  - On the B handshake: capture i_axi_bresp, go to RSP.
- READ:
  - o_axi_arvalid asserts; it drops after the AR handshake.
  - o_axi_rready is 1 for the whole of READ. A slave cannot legally return R before AR, so this is safe.
  - On the R handshake: capture i_axi_rdata and i_axi_rresp, go to RSP.
- RSP:
  - o_rsp_valid = 1; all o_rsp_* outputs stay stable until i_rsp_ready.
  - On the handshake → IDLE.
- Valid signals never drop before their handshake. Address and data are stable while their valid is high (AXI rule).
- Watchdog:
  - Counter clears on command accept and increments each cycle in WRITE or READ.
  - When it reaches TIMEOUT_p, o_timeout sets and the counter saturates.
  - The transaction is not aborted; the FSM keeps waiting.
  - o_timeout clears on the next command accept.
- SLVERR and DECERR are passed through in o_rsp_resp. No retry.

## Timing
- All outputs are registered except o_cmd_ready and o_axi_bready, which decode from state and flags.
- Reset values: every output is 0 while rst is asserted. In the first cycle after reset, o_cmd_ready = 1.
- Command accept at cycle T; AXI valids are high from T+1.
- With a zero-wait slave (ready at T+1, B/R valid at T+2):
  - The B or R handshake happens at T+2.
  - o_rsp_valid = 1 at T+3.
  - If i_rsp_ready is high, the next command can be accepted at T+4.
- AW and W handshakes in the same cycle set both done flags at once; bready is high the following cycle.
- The response handshake and i_cmd_valid cannot overlap: o_cmd_ready is low in RSP.
- Reset mid-transaction:
  - The next edge returns to IDLE and clears all valids, flags, the counter and o_timeout.
  - System-level reset resets the slaves in the same cycle.

## Test plan
- Write 0x000000A5 to 0x000 with a zero-wait slave returning OKAY → awvalid/wvalid high at T+1 only; o_rsp_valid at T+3 with resp 2'b00, rdata 0, o_rsp_we 1.
- Read 0x000 after that write, with the slave returning 0xA5 → arvalid at T+1; o_rsp_valid at T+3 with rdata 0x000000A5, resp 2'b00.
- Write to 0x004 with the slave returning SLVERR; read 0x008 returning 0xDEADDEAD/SLVERR → resp 2'b10 on both; rdata 0xDEADDEAD on the read.
- Slave asserts wready at T+1 and awready at T+4 → wvalid low from T+2, awvalid held and address stable until T+4, bready first high at T+5, exactly one response.
- Hold i_rsp_ready low 5 cycles in RSP → o_rsp_* stable throughout; cmd_ready stays low.
- TIMEOUT_p=8 with arready withheld 20 cycles → o_timeout rises 8 cycles after entering READ; the read still completes; o_timeout clears on the next accept. Asserting rst mid-write → all outputs 0, o_cmd_ready 1 after reset.
